// File: rtl/ukf_fifo_readout.sv
// Read-side controller for the UKF diag/lower result FIFOs: streams a size header,
// the N diagonal words, then the N(N-1)/2 lower words on a registered valid/ready port.
//
// state  | meaning
// IDLE   | waiting for start; illegal N pulses size_error
// HEADER | size header word held in the output register
// DIAG   | draining N words from the diag FIFO
// LOWER  | draining N(N-1)/2 words from the lower FIFO
// FLUSH  | waiting for the final capture and accept, then done
module ukf_fifo_readout #(
    parameter int DATA_W = 128,
    parameter int MAX_N  = 8
) (
    input  logic              slow_clock,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        matrix_size,
    input  logic              empty_diag,
    input  logic              empty_lower,
    input  logic [DATA_W-1:0] fifo_out_diag,
    input  logic [DATA_W-1:0] fifo_out_lower,
    output logic              fifo_rde_diag,
    output logic              fifo_rde_lower,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              size_error
);

    typedef enum logic [2:0] {IDLE, HEADER, DIAG, LOWER, FLUSH} state_t;

    localparam logic [3:0] MAX_N_L = 4'(MAX_N);

    state_t      state, state_next;
    logic [3:0]  diag_left;
    logic [6:0]  lower_left;
    logic        in_flight;
    logic        in_flight_lower;
    logic        in_flight_last;
    logic        accept;
    logic        out_free;
    logic        size_bad;
    logic        rd_last;
    logic [6:0]  lower_calc;

    always_comb begin
        accept         = out_valid & out_ready;
        out_free       = ~out_valid | accept;
        size_bad       = (matrix_size == 4'd0) || (matrix_size > MAX_N_L);
        lower_calc     = 7'(({4'd0, matrix_size} * ({4'd0, matrix_size} - 8'd1)) >> 1);
        state_next     = state;
        fifo_rde_diag  = 1'b0;
        fifo_rde_lower = 1'b0;
        case (state)
            IDLE: begin
                if (start && !size_bad) state_next = HEADER;
            end
            HEADER: begin
                if (accept) state_next = DIAG;
            end
            DIAG: begin
                if (diag_left == 4'd0)
                    state_next = (lower_left != 7'd0) ? LOWER : FLUSH;
                else if (!empty_diag && !in_flight && out_free)
                    fifo_rde_diag = 1'b1;
            end
            LOWER: begin
                if (lower_left == 7'd0)
                    state_next = FLUSH;
                else if (!empty_lower && !in_flight && out_free)
                    fifo_rde_lower = 1'b1;
            end
            FLUSH: begin
                // Only the final word can be pending once nothing is in flight.
                if (!in_flight && accept) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        rd_last = fifo_rde_lower ? (lower_left == 7'd1)
                                 : ((diag_left == 4'd1) && (lower_left == 7'd0));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge slow_clock or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            diag_left       <= '0;
            lower_left      <= '0;
            in_flight       <= 1'b0;
            in_flight_lower <= 1'b0;
            in_flight_last  <= 1'b0;
            out_data        <= '0;
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            done            <= 1'b0;
            size_error      <= 1'b0;
        end else begin
            state      <= state_next;
            done       <= 1'b0;
            size_error <= 1'b0;
            if (state == IDLE && start) begin
                if (size_bad) begin
                    size_error <= 1'b1;
                end else begin
                    diag_left  <= matrix_size;
                    lower_left <= lower_calc;
                    out_data   <= DATA_W'(matrix_size);
                    out_valid  <= 1'b1;
                    out_last   <= 1'b0;
                end
            end else begin
                if (accept) out_valid <= 1'b0;
                // Reads are only issued into a free register, so capture never overwrites.
                if (in_flight) begin
                    out_data  <= in_flight_lower ? fifo_out_lower : fifo_out_diag;
                    out_valid <= 1'b1;
                    out_last  <= in_flight_last;
                end
                in_flight <= fifo_rde_diag | fifo_rde_lower;
                if (fifo_rde_diag) begin
                    diag_left       <= diag_left - 4'd1;
                    in_flight_lower <= 1'b0;
                    in_flight_last  <= rd_last;
                end
                if (fifo_rde_lower) begin
                    lower_left      <= lower_left - 7'd1;
                    in_flight_lower <= 1'b1;
                    in_flight_last  <= rd_last;
                end
                if (state == FLUSH && state_next == IDLE) done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ukf_fifo_readout.sv
// Directed bench for ukf_fifo_readout: FIFO models feed the DUT, a collector records
// the accepted stream, and each table vector is compared against its expected stream.
module tb_ukf_fifo_readout;

    localparam int DW = 128;

    logic          slow_clock = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    matrix_size = 4'd0;
    logic          empty_diag, empty_lower;
    logic [DW-1:0] fifo_out_diag = '0;
    logic [DW-1:0] fifo_out_lower = '0;
    logic          fifo_rde_diag, fifo_rde_lower;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last, busy, done, size_error;

    ukf_fifo_readout #(.DATA_W(DW), .MAX_N(8)) dut (
        .slow_clock     (slow_clock),
        .rst            (rst),
        .start          (start),
        .matrix_size    (matrix_size),
        .empty_diag     (empty_diag),
        .empty_lower    (empty_lower),
        .fifo_out_diag  (fifo_out_diag),
        .fifo_out_lower (fifo_out_lower),
        .fifo_rde_diag  (fifo_rde_diag),
        .fifo_rde_lower (fifo_rde_lower),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done),
        .size_error     (size_error)
    );

    always #5 slow_clock = ~slow_clock;

    // FIFO models: written by the stimulus process, read by the monitor on rde.
    logic [DW-1:0] mem_d [0:255];
    logic [DW-1:0] mem_l [0:255];
    int d_wr = 0, d_rd = 0, l_wr = 0, l_rd = 0;
    assign empty_diag  = (d_wr == d_rd);
    assign empty_lower = (l_wr == l_rd);

    bit toggle_mode = 1'b0;
    always @(negedge slow_clock) out_ready <= toggle_mode ? ~out_ready : 1'b1;

    logic [DW-1:0] got_data [0:511];
    logic          got_last [0:511];
    int got_n = 0, rd_d_cnt = 0, rd_l_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, viol = 0;
    logic          prev_rde = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge slow_clock) begin
        if (fifo_rde_diag) begin
            fifo_out_diag <= mem_d[d_rd[7:0]];
            d_rd          <= d_rd + 1;
            rd_d_cnt      <= rd_d_cnt + 1;
        end
        if (fifo_rde_lower) begin
            fifo_out_lower <= mem_l[l_rd[7:0]];
            l_rd           <= l_rd + 1;
            rd_l_cnt       <= rd_l_cnt + 1;
        end
        if ((fifo_rde_diag && empty_diag) || (fifo_rde_lower && empty_lower) ||
            ((fifo_rde_diag || fifo_rde_lower) && prev_rde) ||
            (fifo_rde_diag && fifo_rde_lower) ||
            (rst && prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last)))
            viol <= viol + 1;
        prev_rde   <= fifo_rde_diag | fifo_rde_lower;
        prev_stall <= out_valid & ~out_ready;
        prev_data  <= out_data;
        prev_last  <= out_last;
        if (out_valid && out_ready) begin
            got_data[got_n[8:0]] <= out_data;
            got_last[got_n[8:0]] <= out_last;
            got_n                <= got_n + 1;
        end
        if (done)       done_cnt <= done_cnt + 1;
        if (size_error) err_cnt  <= err_cnt + 1;
        if (busy)       busy_cnt <= busy_cnt + 1;
    end

    typedef struct {
        logic [3:0] n;
        int         ndiag;
        int         nlower;
        bit         toggle;
        bit         delay;
        int         exp_rd_d;
        int         exp_rd_l;
        bit         exp_err;
    } vec_t;

    vec_t vecs [0:7];
    int vectors = 0;
    int fails = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_d(input logic [DW-1:0] w);
        mem_d[d_wr[7:0]] = w;
        d_wr++;
    endtask

    task automatic push_l(input logic [DW-1:0] w);
        mem_l[l_wr[7:0]] = w;
        l_wr++;
    endtask

    task automatic run_vec(input int v);
        vec_t          t;
        logic [DW-1:0] exp_data [0:63];
        logic [DW-1:0] dw [0:15];
        int e_n, b_got, b_rd_d, b_rd_l, b_done, b_err, b_busy, b_viol, c, n_got;
        t = vecs[v];
        e_n = 0;
        b_got = got_n; b_rd_d = rd_d_cnt; b_rd_l = rd_l_cnt; b_done = done_cnt;
        b_err = err_cnt; b_busy = busy_cnt; b_viol = viol;
        toggle_mode = t.toggle;
        if (!t.exp_err) begin
            exp_data[e_n] = DW'(t.n);
            e_n++;
        end
        for (int i = 0; i < t.ndiag; i++) begin
            dw[i] = {32'(v + 1), 64'h0123_4567_89ab_cdef, 32'hD000_0000 + 32'(i)};
            exp_data[e_n] = dw[i];
            e_n++;
            if (!t.delay) push_d(dw[i]);
        end
        for (int i = 0; i < t.nlower; i++) begin
            exp_data[e_n] = {32'(v + 1), 64'hfedc_ba98_7654_3210, 32'hA000_0000 + 32'(i)};
            push_l(exp_data[e_n]);
            e_n++;
        end
        @(negedge slow_clock);
        start = 1'b1;
        matrix_size = t.n;
        @(negedge slow_clock);
        start = 1'b0;
        matrix_size = 4'hf;
        if (t.delay) begin
            repeat (12) @(negedge slow_clock);
            check($sformatf("v%0d no diag read while empty", v), DW'(rd_d_cnt - b_rd_d), DW'(0));
            for (int i = 0; i < t.ndiag; i++) push_d(dw[i]);
        end
        if (t.exp_err) begin
            repeat (6) @(negedge slow_clock);
            check($sformatf("v%0d busy cycles", v), DW'(busy_cnt - b_busy), DW'(0));
        end else begin
            c = 0;
            while (c < 3000 && done_cnt == b_done) begin
                @(negedge slow_clock);
                c++;
            end
            check($sformatf("v%0d done before timeout", v), DW'(c < 3000), DW'(1));
            repeat (3) @(negedge slow_clock);
        end
        check($sformatf("v%0d size_error pulses", v), DW'(err_cnt - b_err), DW'(t.exp_err));
        check($sformatf("v%0d done pulses", v), DW'(done_cnt - b_done), DW'(!t.exp_err));
        check($sformatf("v%0d diag reads", v), DW'(rd_d_cnt - b_rd_d), DW'(t.exp_rd_d));
        check($sformatf("v%0d lower reads", v), DW'(rd_l_cnt - b_rd_l), DW'(t.exp_rd_l));
        check($sformatf("v%0d protocol violations", v), DW'(viol - b_viol), DW'(0));
        check($sformatf("v%0d busy after end", v), DW'(busy), DW'(0));
        n_got = got_n - b_got;
        check($sformatf("v%0d word count", v), DW'(n_got), DW'(e_n));
        for (int k = 0; k < e_n && k < n_got; k++) begin
            check($sformatf("v%0d word %0d data", v, k), got_data[(b_got + k) % 512], exp_data[k]);
            check($sformatf("v%0d word %0d last", v, k), DW'(got_last[(b_got + k) % 512]),
                  DW'(k == e_n - 1));
        end
    endtask

    initial begin
        int c, b_done, b_rd_l;
        vecs[0] = '{n: 4'd3, ndiag: 3, nlower: 3,  toggle: 0, delay: 0, exp_rd_d: 3, exp_rd_l: 3,  exp_err: 0};
        vecs[1] = '{n: 4'd1, ndiag: 1, nlower: 0,  toggle: 0, delay: 0, exp_rd_d: 1, exp_rd_l: 0,  exp_err: 0};
        vecs[2] = '{n: 4'd4, ndiag: 4, nlower: 6,  toggle: 1, delay: 0, exp_rd_d: 4, exp_rd_l: 6,  exp_err: 0};
        vecs[3] = '{n: 4'd0, ndiag: 0, nlower: 0,  toggle: 0, delay: 0, exp_rd_d: 0, exp_rd_l: 0,  exp_err: 1};
        vecs[4] = '{n: 4'd9, ndiag: 0, nlower: 0,  toggle: 0, delay: 0, exp_rd_d: 0, exp_rd_l: 0,  exp_err: 1};
        vecs[5] = '{n: 4'd3, ndiag: 3, nlower: 3,  toggle: 0, delay: 1, exp_rd_d: 3, exp_rd_l: 3,  exp_err: 0};
        vecs[6] = '{n: 4'd8, ndiag: 8, nlower: 28, toggle: 1, delay: 0, exp_rd_d: 8, exp_rd_l: 28, exp_err: 0};
        vecs[7] = '{n: 4'd2, ndiag: 2, nlower: 1,  toggle: 0, delay: 0, exp_rd_d: 2, exp_rd_l: 1,  exp_err: 0};

        repeat (3) @(negedge slow_clock);
        check("reset out_valid", DW'(out_valid), DW'(0));
        check("reset out_data", out_data, DW'(0));
        check("reset busy", DW'(busy), DW'(0));
        check("reset rde", DW'({fifo_rde_diag, fifo_rde_lower}), DW'(0));
        rst = 1'b1;
        @(negedge slow_clock);

        for (int v = 0; v < 7; v++) run_vec(v);

        // Abort mid-LOWER: lower FIFO holds one word so the DUT stalls there.
        toggle_mode = 1'b0;
        b_rd_l = rd_l_cnt;
        for (int i = 0; i < 3; i++) push_d(DW'(32'hBAD0_0000 + 32'(i)));
        push_l(DW'(32'hBAD1_0000));
        @(negedge slow_clock);
        start = 1'b1;
        matrix_size = 4'd3;
        @(negedge slow_clock);
        start = 1'b0;
        c = 0;
        while (c < 200 && rd_l_cnt == b_rd_l) begin
            @(negedge slow_clock);
            c++;
        end
        check("abort reached LOWER", DW'(c < 200), DW'(1));
        repeat (2) @(negedge slow_clock);
        check("abort busy before reset", DW'(busy), DW'(1));
        #2 rst = 1'b0;
        #1;
        check("async reset out_valid", DW'(out_valid), DW'(0));
        check("async reset out_data", out_data, DW'(0));
        check("async reset out_last", DW'(out_last), DW'(0));
        check("async reset busy", DW'(busy), DW'(0));
        check("async reset pulses", DW'({done, size_error}), DW'(0));
        check("async reset rde", DW'({fifo_rde_diag, fifo_rde_lower}), DW'(0));
        b_done = done_cnt;
        @(negedge slow_clock);
        rst = 1'b1;
        repeat (5) @(negedge slow_clock);
        check("no done after abort", DW'(done_cnt - b_done), DW'(0));
        check("idle after abort", DW'(busy), DW'(0));

        run_vec(7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
